// File: rtl/debounce_scheduler.sv
// Debounces N_BTN asynchronous buttons with a single shared stability timer.
// Each input is synchronized by two flops; a round-robin scheduler hands the
// timer to one input whose synchronized value disagrees with its debounced
// level, and a confirmed change updates the level and emits a one-cycle
// press/release pulse.
// Optional interrupt output: define DEBOUNCE_IRQ_EN to add irq_clr/irq.
module debounce_scheduler #(
   parameter int unsigned N_BTN         = 4,
   parameter int unsigned STABLE_CYCLES = 16,
   localparam int unsigned IDX_W        = $clog2(N_BTN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             busy,
   output logic [IDX_W-1:0] active_idx
`ifdef DEBOUNCE_IRQ_EN
   ,
   input  logic             irq_clr,
   output logic             irq
`endif
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   // cnt + 1 == STABLE_CYCLES is checked as cnt == STABLE_CYCLES - 1 to avoid overflow
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N_BTN - 1);

   typedef enum logic {StScan, StCount} state_t;

   state_t           state_q;
   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] rr_ptr_q;

   logic [N_BTN-1:0] diff;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] rr_next;
   logic             sample_differs;
   logic             commit;

   assign diff           = sync2_q ^ btn_level;
   assign sample_differs = sync2_q[active_idx] ^ btn_level[active_idx];
   assign commit         = (state_q == StCount) && sample_differs && (cnt_q == CntLast);
   assign rr_next        = (active_idx == IdxLast) ? '0 : active_idx + IDX_W'(1);

   // Two-flop synchronizer per button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   // Round-robin search: first differing input at or after rr_ptr, wrapping explicitly.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = rr_ptr_q;
      for (int k = 0; k < int'(N_BTN); k++) begin
         if (!grant_valid && diff[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
         cand = (cand == IdxLast) ? '0 : cand + IDX_W'(1);
      end
   end

   // Scheduler FSM: grant the timer, count stable samples, commit or abort.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StScan;
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         busy        <= 1'b0;
         active_idx  <= '0;
         cnt_q       <= '0;
         rr_ptr_q    <= '0;
      end else begin
         btn_press   <= '0;
         btn_release <= '0;
         unique case (state_q)
            StScan: begin
               if (grant_valid) begin
                  active_idx <= grant_idx;
                  cnt_q      <= CNT_W'(1);
                  busy       <= 1'b1;
                  state_q    <= StCount;
               end
            end
            StCount: begin
               if (!sample_differs) begin
                  // Bounce: give up ownership, nothing committed.
                  rr_ptr_q <= rr_next;
                  busy     <= 1'b0;
                  state_q  <= StScan;
               end else if (commit) begin
                  btn_level[active_idx] <= ~btn_level[active_idx];
                  if (btn_level[active_idx]) begin
                     btn_release[active_idx] <= 1'b1;
                  end else begin
                     btn_press[active_idx] <= 1'b1;
                  end
                  rr_ptr_q <= rr_next;
                  busy     <= 1'b0;
                  state_q  <= StScan;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= StScan;
         endcase
      end
   end

`ifdef DEBOUNCE_IRQ_EN
   // Sticky interrupt; a commit wins over a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq <= 1'b0;
      end else if (commit) begin
         irq <= 1'b1;
      end else if (irq_clr) begin
         irq <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed, table-driven bench for debounce_scheduler (N_BTN=4, STABLE_CYCLES=4).
module tb_debounce_scheduler;

   localparam int unsigned NB = 4;
   localparam int unsigned SC = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] btn_in = '0;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic          busy;
   logic [1:0]    active_idx;
`ifdef DEBOUNCE_IRQ_EN
   logic          irq_clr = 1'b0;
   logic          irq;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   debounce_scheduler #(
      .N_BTN         (NB),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .busy        (busy),
      .active_idx  (active_idx)
`ifdef DEBOUNCE_IRQ_EN
      ,
      .irq_clr     (irq_clr),
      .irq         (irq)
`endif
   );

   typedef struct {
      logic [3:0] btn;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic       bsy;
      logic [1:0] idx;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [3:0] btn, input logic [3:0] lvl, input logic [3:0] prs,
                      input logic [3:0] rel, input logic bsy, input logic [1:0] idx);
      vec_t v;
      v.btn = btn; v.lvl = lvl; v.prs = prs; v.rel = rel; v.bsy = bsy; v.idx = idx;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                          input logic [3:0] rel, input logic bsy, input logic [1:0] idx);
      chk({tag, ".level"}, 32'(btn_level), 32'(lvl));
      chk({tag, ".press"}, 32'(btn_press), 32'(prs));
      chk({tag, ".release"}, 32'(btn_release), 32'(rel));
      chk({tag, ".busy"}, 32'(busy), 32'(bsy));
      chk({tag, ".idx"}, 32'(active_idx), 32'(idx));
   endtask

   // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic [3:0] b);
      @(negedge clk);
      btn_in = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, got running, expected finished");
      $fatal(1);
   end

   initial begin
      // Clean press on btn2
      add(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
      add(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
      add(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2);
      add(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2);
      add(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2);
      add(4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd2);
      add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2);
      // Bounce on btn0: high 2, low 1, then steady high
      add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2);
      add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2);
      add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd0);
      add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd0);
      add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0);
      add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd0);
      add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd0);
      add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd0);
      add(4'b0101, 4'b0101, 4'b0001, 4'b0000, 1'b0, 2'd0);
      add(4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd0);
      // Press btn3 (rr_ptr=1 after btn0)
      add(4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd0);
      add(4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd0);
      add(4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'd3);
      add(4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'd3);
      add(4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'd3);
      add(4'b1101, 4'b1101, 4'b1000, 4'b0000, 1'b0, 2'd3);
      add(4'b1101, 4'b1101, 4'b0000, 4'b0000, 1'b0, 2'd3);
      // Release btn3 (rr_ptr wrapped to 0)
      add(4'b0101, 4'b1101, 4'b0000, 4'b0000, 1'b0, 2'd3);
      add(4'b0101, 4'b1101, 4'b0000, 4'b0000, 1'b0, 2'd3);
      add(4'b0101, 4'b1101, 4'b0000, 4'b0000, 1'b1, 2'd3);
      add(4'b0101, 4'b1101, 4'b0000, 4'b0000, 1'b1, 2'd3);
      add(4'b0101, 4'b1101, 4'b0000, 4'b0000, 1'b1, 2'd3);
      add(4'b0101, 4'b0101, 4'b0000, 4'b1000, 1'b0, 2'd3);
      add(4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd3);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
`ifdef DEBOUNCE_IRQ_EN
      chk("reset.irq", 32'(irq), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      foreach (vq[i]) begin
         step(vq[i].btn);
         chk_all($sformatf("vec%0d", i), vq[i].lvl, vq[i].prs, vq[i].rel, vq[i].bsy, vq[i].idx);
      end

      // Clear back to a known state
      @(negedge clk);
      btn_in = '0;
      reset  = 1'b1;
      @(negedge clk);
      reset  = 1'b0;

      // Contention: btn0 and btn1 rise together, rr_ptr=0
      step(4'b0011);
      step(4'b0011);
      step(4'b0011);
      chk_all("cont.grant0", 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0);
      step(4'b0011);
      step(4'b0011);
      step(4'b0011);
      chk_all("cont.commit0", 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0);
      step(4'b0011);
      chk_all("cont.grant1", 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd1);
      step(4'b0011);
      step(4'b0011);
      chk_all("cont.pre1", 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd1);
      step(4'b0011);
      chk_all("cont.commit1", 4'b0011, 4'b0010, 4'b0000, 1'b0, 2'd1);
      step(4'b0011);
      chk_all("cont.after1", 4'b0011, 4'b0000, 4'b0000, 1'b0, 2'd1);

      // Reset mid-COUNT: btn2 granted (rr_ptr=2), reset with cnt=2
      step(4'b0111);
      step(4'b0111);
      step(4'b0111);
      chk_all("rst.grant2", 4'b0011, 4'b0000, 4'b0000, 1'b1, 2'd2);
      step(4'b0111);
      #2;
      reset  = 1'b1;
      btn_in = 4'b0100;
      #1;
      chk_all("rst.async", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
`ifdef DEBOUNCE_IRQ_EN
      chk("rst.async.irq", 32'(irq), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      step(4'b0100);
      step(4'b0100);
      chk_all("rst.regrant", 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2);
      step(4'b0100);
      step(4'b0100);
      chk_all("rst.window", 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2);
      step(4'b0100);
      chk_all("rst.commit", 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd2);

`ifdef DEBOUNCE_IRQ_EN
      chk("irq.set", 32'(irq), 32'd1);
      @(negedge clk);
      irq_clr = 1'b1;
      @(posedge clk);
      #1;
      irq_clr = 1'b0;
      chk("irq.clr", 32'(irq), 32'd0);
      // Release btn2 with irq_clr coincident with the commit edge
      step(4'b0000);
      step(4'b0000);
      step(4'b0000);
      step(4'b0000);
      step(4'b0000);
      chk("irq.idle", 32'(irq), 32'd0);
      @(negedge clk);
      irq_clr = 1'b1;
      @(posedge clk);
      #1;
      irq_clr = 1'b0;
      chk("irq.coinc.rel", 32'(btn_release), 32'(4'b0100));
      chk("irq.coinc", 32'(irq), 32'd1);
      step(4'b0000);
      chk("irq.hold", 32'(irq), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces N_BTN asynchronous push-button inputs using one shared stability timer instead of a counter per button.
- Each input passes through a 2-FF synchronizer.
- A round-robin scheduler grants the timer to one input whose synchronized value differs from its debounced level.
- On a confirmed change the block updates the debounced level and emits a one-cycle press or release pulse to downstream control logic.

Parameters:
- N_BTN, 4, number of button inputs (>=2).
- STABLE_CYCLES, 16, consecutive differing samples required to commit a change (>=2).
- IDX_W, $clog2(N_BTN), derived localparam; width of the index.
- CNT_W, $clog2(STABLE_CYCLES+1), derived localparam; width of the counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_in  input  N_BTN  raw asynchronous button inputs.
- btn_level  output  N_BTN  debounced levels.
- btn_press  output  N_BTN  one-cycle pulse on the bit whose level committed 0->1.
- btn_release  output  N_BTN  one-cycle pulse on the bit whose level committed 1->0.
- busy  output  1  high while in COUNT.
- active_idx  output  IDX_W  index currently owning the timer; holds last granted index otherwise.

Behaviour:
- Reset (async, active-high): synchronizer FFs, btn_level, btn_press, btn_release, busy, active_idx, counter and rr_ptr all clear to 0; state goes to SCAN. Asserting reset mid-COUNT discards the pending change, and no pulse is emitted.
- Synchronizer: 2 FFs per bit. sync = second stage. diff = sync ^ btn_level.
- SCAN state:
  - If diff == 0, stay in SCAN.
  - Otherwise grant the first set bit of diff, searching upward from rr_ptr with wrap from N_BTN-1 to 0.
  - On the grant: active_idx <= granted index; cnt <= 1; state <= COUNT; busy goes high.
- COUNT state, per edge, samples sync[active_idx]:
  - Sample equals btn_level[active_idx] (bounce): abort. state <= SCAN; rr_ptr <= active_idx+1 mod N_BTN; nothing is committed.
  - Sample differs and cnt+1 == STABLE_CYCLES: commit.
    - btn_level[active_idx] toggles.
    - btn_press or btn_release[active_idx] goes high for exactly one cycle.
    - rr_ptr <= active_idx+1 mod N_BTN; state <= SCAN.
  - Otherwise cnt <= cnt+1.
- Commit timing: the commit edge is STABLE_CYCLES-1 edges after the detection edge. The uncontended latency from the first clk edge that samples the new btn_in value to btn_level changing is STABLE_CYCLES+1 edges.
- Ownership: other inputs are ignored during COUNT. Their diff persists, so they are serviced on later SCAN passes; no change is ever lost once it is held stable.
- Simultaneous changes: serviced one at a time in round-robin order. Each new grant costs one SCAN cycle.
- Pulses: btn_press and btn_release are registered and at most one bit of either is set in any cycle. They deassert on the next edge.
- Arithmetic: rr_ptr wrap uses explicit compare against N_BTN-1; non-power-of-two N_BTN must work. The counter never exceeds STABLE_CYCLES-1.

Optional Feature:
- Macro: DEBOUNCE_IRQ_EN.
- Defined: adds input irq_clr (1 bit) and output irq (1 bit).
  - irq resets to 0.
  - Sets on any press or release commit; holds until irq_clr is sampled high.
  - A commit and irq_clr in the same cycle leave irq = 1.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Clean press, STABLE_CYCLES=4: btn_in[2] rises cleanly and holds, first sampled at edge P0 -> btn_level[2]=1 and btn_press[2]=1 after edge P5; btn_press[2]=0 after P6; busy high only across the COUNT cycles.
- Bounce: btn_in[0] high for 2 cycles, low for 1, then high steady -> abort after the first bounce, no pulse during it; one btn_press[0] once STABLE_CYCLES consecutive differing samples are seen.
- Contention, rr_ptr=0: btn_in[0] and btn_in[1] rise on the same edge P0 -> btn0 commits at P5; btn1 is detected at P6 and commits at P9; active_idx reads 0 then 1.
- Release: with btn_level[3]=1, btn_in[3] falls and holds -> btn_release[3] pulses once; btn_level[3]=0; btn_press stays 0.
- Reset mid-COUNT: assert reset asynchronously with cnt=2 -> all outputs are 0 immediately; after reset deasserts with btn_in still high, a full new STABLE_CYCLES window is required before the press commits.
- IRQ (macro defined): press commit -> irq=1; irq_clr pulse -> irq=0; commit coincident with irq_clr -> irq remains 1.
